// File: rtl/player_life_pkg.sv
// player_life_pkg
// Shared types and widths for the player life-cycle controller and the
// frame counter it uses.
//   life_state_t : FSM state encoding (visible on state_dbg)
//   LIVES_W      : width of the lives counter
//   FRAME_CNT_W  : width of the per-state frame counter
package player_life_pkg;

    localparam int LIVES_W     = 3;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        DYING     = 3'd1,
        RESPAWN   = 3'd2,
        INVULN    = 3'd3,
        GAME_OVER = 3'd4
    } life_state_t;

    // Lives never wrap below zero.
    function automatic logic [LIVES_W-1:0] lives_dec_sat(input logic [LIVES_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// frame_counter
// Counts video frames (startOfFrame pulses). A synchronous clear takes
// priority over counting, so a frame strobe arriving in the same cycle as
// a clear is dropped and the counter restarts from zero.
// Ports:
//   clk          : system clock
//   resetN       : asynchronous active-low reset
//   clear        : synchronous clear to zero
//   startOfFrame : one-cycle pulse per video frame
//   count        : current frame count
module frame_counter
    import player_life_pkg::*;
#(
    parameter int W = FRAME_CNT_W
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clear,
    input  logic         startOfFrame,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (startOfFrame) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/player_life_ctrl.sv
// player_life_ctrl
// Sequences the player through PLAY -> DYING -> RESPAWN -> INVULN -> PLAY,
// ending in GAME_OVER when the last life is spent. new_game restarts from
// any state.
// Optional feature: define PLAYER_EXTRA_LIFE_EN to let bonus_life add a
// life (saturating at MAX_LIVES) in every state except GAME_OVER. Without
// it bonus_life is ignored.
// Ports:
//   clk, resetN   : clock, asynchronous active-low reset
//   startOfFrame  : one-cycle pulse per video frame
//   player_hit    : raw collision level from collision logic
//   new_game      : one-cycle restart request
//   bonus_life    : one-cycle extra-life pulse
//   playerDR_in   : drawing request from the player block
//   playerDR_out  : blink/game-over gated drawing request (combinational)
//   player_rst_n  : active-low reset to the player block (low in RESPAWN)
//   move_enable   : registered enable for the arrow inputs
//   lives         : remaining lives (registered)
//   game_over     : registered, high in GAME_OVER
//   state_dbg     : current FSM state encoding
module player_life_ctrl
    import player_life_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 7,
    parameter int DEATH_FRAMES  = 64,
    parameter int INVULN_FRAMES = 96,
    parameter int BLINK_LOG2    = 3
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               player_hit,
    input  logic               new_game,
    input  logic               bonus_life,
    input  logic               playerDR_in,
    output logic               playerDR_out,
    output logic               player_rst_n,
    output logic               move_enable,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic [2:0]         state_dbg
);

    localparam logic [LIVES_W-1:0]     INIT_L     = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0]     MAX_L      = LIVES_W'(MAX_LIVES);
    localparam logic [FRAME_CNT_W-1:0] DEATH_LAST = FRAME_CNT_W'(DEATH_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] INV_LAST   = FRAME_CNT_W'(INVULN_FRAMES - 1);

    life_state_t             state;
    life_state_t             next_state;
    logic [LIVES_W-1:0]      lives_next;
    logic [FRAME_CNT_W-1:0]  frame_cnt;
    logic                    cnt_clear;
    logic                    lose_life;
    logic                    rst_flag;

    // Any state change restarts the frame count. new_game also clears it,
    // since a restart from RESPAWN does not change the state.
    assign cnt_clear = (next_state != state) || new_game;

    frame_counter #(
        .W (FRAME_CNT_W)
    ) u_frame_counter (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (cnt_clear),
        .startOfFrame (startOfFrame),
        .count        (frame_cnt)
    );

    // Next-state and next-lives. new_game wins over everything else; a hit
    // is only honoured in PLAY, and the timeouts look at the frame strobe
    // that completes the last frame of the phase.
    always_comb begin
        next_state = state;
        lives_next = lives;
        lose_life  = 1'b0;
        if (new_game) begin
            next_state = RESPAWN;
            lives_next = INIT_L;
        end else begin
            unique case (state)
                PLAY: begin
                    if (player_hit) begin
                        next_state = DYING;
                        lose_life  = 1'b1;
                        lives_next = lives_dec_sat(lives);
                    end
                end
                DYING: begin
                    if (startOfFrame && frame_cnt == DEATH_LAST) begin
                        next_state = (lives == '0) ? GAME_OVER : RESPAWN;
                    end
                end
                RESPAWN: begin
                    next_state = INVULN;
                end
                INVULN: begin
                    if (startOfFrame && frame_cnt == INV_LAST) begin
                        next_state = PLAY;
                    end
                end
                GAME_OVER: begin
                    next_state = GAME_OVER;
                end
                default: begin
                    next_state = PLAY;
                end
            endcase
`ifdef PLAYER_EXTRA_LIFE_EN
            // A bonus arriving with the death decrement cancels it out.
            if (bonus_life && state != GAME_OVER) begin
                if (lose_life) begin
                    lives_next = lives;
                end else if (lives != MAX_L) begin
                    lives_next = lives + 1'b1;
                end
            end
`endif
        end
    end

`ifndef PLAYER_EXTRA_LIFE_EN
    logic unused_bonus_life;
    assign unused_bonus_life = bonus_life;
`endif

    // State, lives and the registered outputs. Outputs are derived from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= PLAY;
            lives       <= INIT_L;
            rst_flag    <= 1'b1;
            move_enable <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            state       <= next_state;
            lives       <= lives_next;
            rst_flag    <= (next_state != RESPAWN);
            move_enable <= (next_state == PLAY) || (next_state == INVULN);
            game_over   <= (next_state == GAME_OVER);
        end
    end

    assign player_rst_n = resetN & rst_flag;
    assign state_dbg    = state;

    // Draw path stays combinational. In INVULN the player is hidden on odd
    // blink half-periods, so the first half-period after respawn is visible.
    always_comb begin
        playerDR_out = playerDR_in;
        unique case (state)
            INVULN:    playerDR_out = playerDR_in & ~frame_cnt[BLINK_LOG2];
            GAME_OVER: playerDR_out = 1'b0;
            default:   playerDR_out = playerDR_in;
        endcase
    end

endmodule

// File: tb/tb_player_life_ctrl.sv
// tb_player_life_ctrl
// Self-checking bench for player_life_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model
// of the life-cycle rules, plus literal expectations at key points.
// Honors PLAYER_EXTRA_LIFE_EN the same way the design does.
module tb_player_life_ctrl;

    localparam int INIT_L  = 3;
    localparam int MAX_L   = 7;
    localparam int DEATH_F = 64;
    localparam int INV_F   = 96;
    localparam int BLINK_F = 8;

    localparam int S_PLAY = 0, S_DYING = 1, S_RESPAWN = 2, S_INVULN = 3, S_OVER = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       player_hit;
    logic       new_game;
    logic       bonus_life;
    logic       playerDR_in;
    logic       playerDR_out;
    logic       player_rst_n;
    logic       move_enable;
    logic [2:0] lives;
    logic       game_over;
    logic [2:0] state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct packed {
        int st;
        int fr;
        int lv;
    } model_t;

    model_t m;

    player_life_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .player_hit   (player_hit),
        .new_game     (new_game),
        .bonus_life   (bonus_life),
        .playerDR_in  (playerDR_in),
        .playerDR_out (playerDR_out),
        .player_rst_n (player_rst_n),
        .move_enable  (move_enable),
        .lives        (lives),
        .game_over    (game_over),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // One step of the life-cycle rules: phase, frames spent in that phase,
    // and lives remaining.
    function automatic model_t model_next(input model_t cur, input bit hit, input bit sof,
                                          input bit ng, input bit bl);
        model_t n;
        bit     bonus_on;
`ifdef PLAYER_EXTRA_LIFE_EN
        bonus_on = 1'b1;
`else
        bonus_on = 1'b0;
`endif
        n = cur;
        if (ng) begin
            n.st = S_RESPAWN;
            n.lv = INIT_L;
        end else begin
            if (cur.st == S_PLAY && hit) begin
                n.st = S_DYING;
                n.lv = (cur.lv > 0) ? cur.lv - 1 : 0;
            end else if (cur.st == S_DYING && sof && cur.fr + 1 == DEATH_F) begin
                n.st = (cur.lv == 0) ? S_OVER : S_RESPAWN;
            end else if (cur.st == S_RESPAWN) begin
                n.st = S_INVULN;
            end else if (cur.st == S_INVULN && sof && cur.fr + 1 == INV_F) begin
                n.st = S_PLAY;
            end
            if (bl && bonus_on && cur.st != S_OVER) begin
                if (cur.st == S_PLAY && hit) n.lv = cur.lv;
                else                         n.lv = (cur.lv + 1 > MAX_L) ? MAX_L : cur.lv + 1;
            end
        end
        if (ng || n.st != cur.st) n.fr = 0;
        else if (sof)             n.fr = cur.fr + 1;
        return n;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) m <= '{S_PLAY, 0, INIT_L};
        else         m <= model_next(m, player_hit, startOfFrame, new_game, bonus_life);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every output against what the model says it must be right now.
    task automatic compareModel();
        int exp_dr;
        if (m.st == S_OVER)        exp_dr = 0;
        else if (m.st == S_INVULN) exp_dr = int'(playerDR_in && ((m.fr / BLINK_F) % 2 == 0));
        else                       exp_dr = int'(playerDR_in);
        checkOutput("state_dbg",    int'(state_dbg),    m.st);
        checkOutput("lives",        int'(lives),        m.lv);
        checkOutput("move_enable",  int'(move_enable),  int'(m.st == S_PLAY || m.st == S_INVULN));
        checkOutput("game_over",    int'(game_over),    int'(m.st == S_OVER));
        checkOutput("player_rst_n", int'(player_rst_n), int'(resetN && m.st != S_RESPAWN));
        checkOutput("playerDR_out", int'(playerDR_out), exp_dr);
    endtask

    // Drive inputs just after a rising edge, check at the falling edge,
    // and return 1ns after the next rising edge.
    task automatic applyStimulus(input bit h, input bit s, input bit ng, input bit bl, input bit dr);
        player_hit   = h;
        startOfFrame = s;
        new_game     = ng;
        bonus_life   = bl;
        playerDR_in  = dr;
        @(negedge clk);
        compareModel();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle with a frame strobe every other cycle until the model reaches the
    // target phase or the budget runs out; the DUT must be there too.
    task automatic waitFor(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (m.st != target && n < budget) begin
            applyStimulus(1'b0, (cyc % 2) == 0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput(name, int'(state_dbg), target);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_lives;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        player_hit   = 1'b0;
        new_game     = 1'b0;
        bonus_life   = 1'b0;
        playerDR_in  = 1'b1;

        // Reset values
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_player_rst_n", int'(player_rst_n), 0);
        checkOutput("rst_state",        int'(state_dbg),    S_PLAY);
        checkOutput("rst_lives",        int'(lives),        3);
        checkOutput("rst_move_enable",  int'(move_enable),  1);
        checkOutput("rst_game_over",    int'(game_over),    0);
        resetN = 1'b1;

        // Hit -> DYING, death timeout -> one-cycle RESPAWN -> INVULN
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("hit_state",       int'(state_dbg),   S_DYING);
        checkOutput("hit_lives",       int'(lives),       2);
        checkOutput("hit_move_enable", int'(move_enable), 0);
        waitFor(S_RESPAWN, 1000, "dying_to_respawn");
        checkOutput("respawn_rst_low", int'(player_rst_n), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("respawn_one_cycle", int'(state_dbg),    S_INVULN);
        checkOutput("invuln_rst_high",   int'(player_rst_n), 1);
        checkOutput("invuln_visible0",   int'(playerDR_out), 1);

        // Blink: 8 frames visible, 8 hidden, 8 visible; hits ignored
        for (int i = 0; i < 16; i++) applyStimulus(i < 6, (i % 2) == 0, 1'b0, 1'b0, 1'b1);
        checkOutput("blink_hidden",    int'(playerDR_out), 0);
        checkOutput("invuln_hit_ign",  int'(state_dbg),    S_INVULN);
        checkOutput("invuln_lives",    int'(lives),        2);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0, 1'b0, 1'b1);
        checkOutput("blink_visible",   int'(playerDR_out), 1);
        waitFor(S_PLAY, 1000, "invuln_to_play");

        // Long hit: exactly one decrement
        repeat (200) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("long_hit_state", int'(state_dbg), S_DYING);
        checkOutput("long_hit_lives", int'(lives),     1);

        // new_game at DYING frame 30 (with a simultaneous frame strobe)
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("ng_state", int'(state_dbg),    S_RESPAWN);
        checkOutput("ng_lives", int'(lives),        3);
        checkOutput("ng_rst",   int'(player_rst_n), 0);

        // Three deaths -> GAME_OVER
        for (int k = 0; k < 3; k++) begin
            waitFor(S_PLAY, 2000, "deaths_play");
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            waitFor((k == 2) ? S_OVER : S_RESPAWN, 2000, "deaths_exit");
        end
        checkOutput("over_flag",  int'(game_over),    1);
        checkOutput("over_lives", int'(lives),        0);
        checkOutput("over_dr",    int'(playerDR_out), 0);
        checkOutput("over_move",  int'(move_enable),  0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("over_sticky", int'(state_dbg), S_OVER);
        checkOutput("over_no_bonus", int'(lives), 0);

        // Bonus lives
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        waitFor(S_PLAY, 2000, "bonus_play");
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef PLAYER_EXTRA_LIFE_EN
        exp_lives = 7;
`else
        exp_lives = 3;
`endif
        checkOutput("bonus_sat", int'(lives), exp_lives);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef PLAYER_EXTRA_LIFE_EN
        exp_lives = 7;
`else
        exp_lives = 2;
`endif
        checkOutput("bonus_with_hit", int'(lives), exp_lives);

        // Randomized traffic, including mid-operation resets
        for (int i = 0; i < 5000; i++) begin
            bit h, s, ng, bl, dr;
            h  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 2) == 0);
            ng = (m.st == S_OVER) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
            bl = ($urandom_range(0, 29) == 0);
            dr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) < 2) begin
                resetN = 1'b0;
                applyStimulus(h, s, ng, bl, dr);
                resetN = 1'b1;
            end else begin
                applyStimulus(h, s, ng, bl, dr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
